demux14_pipe: RTL and testbench
===============================

# demux14_pipe

Registered 1-to-4 demultiplexer with valid/ready handshake on every port. It steers one WIDTH-bit word per cycle to the output channel selected by `in_sel`, into that channel's one-entry holding register. It is the fan-out counterpart to the pipeline's 2:1/4:1 selectors: it routes a single producer (e.g. a result bus) to one of four consumers, and each consumer can stall on its own.

## Interface
- WIDTH, 16: data word width in bits.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- flush  input  1  synchronous clear of all channel registers.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  word to route.
- in_sel  input  2  destination channel, 0..3.
- out_valid  output  4  bit k set: channel k holds a word.
- out_ready  input  4  bit k set: consumer k takes its word this cycle.
- out_data0, out_data1, out_data2, out_data3  output  WIDTH  channel k word.
- occupancy  output  3  number of channels currently holding a word, 0..4.

## Operation
- Per channel k:
  - Holding register data_k and flag out_valid[k].
  - out_data_k is driven directly from data_k.
- Drain: out_valid[k] && out_ready[k] at a clock edge clears out_valid[k] at that edge, unless the same channel reloads in the same cycle.
- in_ready is combinational: `!flush && (!out_valid[in_sel] || out_ready[in_sel])`.
  - It is valid regardless of in_valid.
  - It depends on in_sel and on only the selected channel's state.
- Accept: in_valid && in_ready at an edge loads data_s with in_data and sets out_valid[s], where s = in_sel.
- Simultaneous drain and accept on the same channel: the old word leaves, the new word is loaded, out_valid[s] stays 1. Full throughput of one word per cycle per channel.
- Accept on channel s and drain on channel j≠s in the same cycle are independent.
- Unselected channels never change on an accept.
- out_data_k must stay stable while out_valid[k] && !out_ready[k].
- data_k is not cleared on drain. It retains its last value while out_valid[k]=0.
- flush=1 at an edge:
  - Clears all out_valid bits.
  - Forces in_ready=0, so nothing is accepted that cycle.
  - data_k is unchanged.
  - flush has priority over accept and drain.
- in_sel and in_data are don't-care when in_valid=0. No state changes from them.
- occupancy is the combinational popcount of out_valid.
- No ordering across channels. Per channel, words exit in acceptance order; depth is one word.

## Timing
- Reset (rst_n=0, asynchronous), effective immediately with no clock required:
  - out_valid = 4'b0000.
  - All data_k = 0, so every out_data_k = 0.
  - occupancy = 0.
  - in_ready = !flush.
- Reset release is synchronous to clk. The first accept is possible at the first rising edge after rst_n rises.
- Latency: a word accepted at edge N appears on out_data_s with out_valid[s]=1 after edge N. Its earliest drain is at edge N+1.
- Reset asserted mid-transfer discards every held word. No output handshake completes at or after the reset edge.
- Back-pressure: a channel that is full and stalled (out_ready[s]=0) holds in_ready low for words targeting it. The producer must hold in_valid, in_data and in_sel until acceptance.
- No combinational path from in_valid or in_data to any output. The only combinational paths are in_sel, out_ready and flush to in_ready.

## Test plan
- Reset: assert rst_n=0 mid-cycle with all channels full -> out_valid=0000, out_data0..3=0x0000 and occupancy=0 before the next edge; in_ready=1 with flush=0.
- Basic routing: out_ready=0000; send 0x1111 sel=0, 0x2222 sel=1, 0x3333 sel=2, 0x4444 sel=3 on consecutive cycles -> each word accepted the cycle it is presented, out_valid=1111, out_data0..3=0x1111/0x2222/0x3333/0x4444, occupancy=4.
- Stall: with channel 2 full and out_ready[2]=0, present 0xAAAA sel=2 -> in_ready=0 and 0x3333 held for 5 cycles; raise out_ready[2] -> 0xAAAA accepted that edge, out_data2=0xAAAA next cycle with out_valid[2] still 1.
- Streaming: out_ready=1111; send 8 back-to-back words sel=1, 0x0001..0x0008 -> in_ready=1 every cycle; consumer 1 sees 0x0001..0x0008 in order, one per cycle.
- Flush priority: channels 0 and 3 full; assert flush with in_valid=1, sel=0 -> in_ready=0, out_valid=0000 next cycle, occupancy=0, out_data0 unchanged.
- Independence: channel 0 full and stalled, channel 1 draining; present a word for sel=3 -> accepted; out_valid[0] stays 1, out_valid[1] clears, out_valid[3] sets in the same edge.

Source files
------------

// File: rtl/demux14_pipe_if.sv
// Handshake bundle for the 1-to-4 registered demux: one producer port, four consumer channels.
interface demux14_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [2:0]       occupancy;

  // Producer/consumer side (drives inputs of the block, observes its outputs)
  modport master (
    output flush, in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, occupancy
  );

  // Block side
  modport slave (
    input  flush, in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, occupancy
  );
endinterface

// File: rtl/demux14_pipe.sv
// Registered 1-to-4 demultiplexer: steers one word per cycle into the selected
// channel's one-entry holding register; each consumer drains independently.
module demux14_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  demux14_pipe_if.slave  bus
);

  localparam int unsigned NCH   = 4;
  localparam int unsigned OCC_W = 3;

  logic [NCH-1:0]   vld_q;
  logic [NCH-1:0]   vld_d;
  logic [WIDTH-1:0] data_q [NCH];
  logic [NCH-1:0]   load_c;
  logic             in_ready_c;
  logic             accept_c;
  logic [OCC_W-1:0] occ_c;

  // Ready looks only at the selected channel, so a stall on one consumer never blocks others
  assign in_ready_c = !bus.flush && (!vld_q[bus.in_sel] || bus.out_ready[bus.in_sel]);
  assign accept_c   = bus.in_valid && in_ready_c;

  // Per-channel load enables and next valid; flush overrides both drain and accept
  always_comb begin
    load_c = '0;
    vld_d  = vld_q & ~bus.out_ready;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (accept_c && (bus.in_sel == 2'(k))) begin
        load_c[k] = 1'b1;
        vld_d[k]  = 1'b1;
      end
    end
    if (bus.flush) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int unsigned k = 0; k < NCH; k++) begin
        if (load_c[k]) begin
          data_q[k] <= bus.in_data;
        end
      end
    end
  end

  always_comb begin
    occ_c = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      occ_c = occ_c + OCC_W'(vld_q[k]);
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = vld_q;
  assign bus.out_data0 = data_q[0];
  assign bus.out_data1 = data_q[1];
  assign bus.out_data2 = data_q[2];
  assign bus.out_data3 = data_q[3];
  assign bus.occupancy = occ_c;

endmodule

// File: tb/tb_demux14_pipe.sv
// Self-checking bench for demux14_pipe: per-cycle comparison against a behavioural
// channel model plus directed literal expectations.
module tb_demux14_pipe;

  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  demux14_pipe_if #(.WIDTH(WIDTH)) bus ();

  demux14_pipe #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: each channel is a slot that is either empty or holds one word
  bit         m_full [4];
  logic [15:0] m_word [4];

  // Words consumer 1 actually took, captured from the DUT
  logic [15:0] log1 [16];
  int          log1_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_word(input int k);
    case (k)
      0: return bus.out_data0;
      1: return bus.out_data1;
      2: return bus.out_data2;
      default: return bus.out_data3;
    endcase
  endfunction

  function automatic logic model_ready();
    int s;
    s = int'(bus.in_sel);
    return !bus.flush && (!m_full[s] || bus.out_ready[s]);
  endfunction

  // Model state update at each edge from the rules: flush empties all, drain empties, accept fills
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_full[k] = 1'b0;
        m_word[k] = 16'h0000;
      end
    end else if (bus.flush) begin
      for (int k = 0; k < 4; k++) m_full[k] = 1'b0;
    end else begin
      logic acc;
      int   s;
      acc = bus.in_valid && model_ready();
      s   = int'(bus.in_sel);
      for (int k = 0; k < 4; k++) begin
        if (m_full[k] && bus.out_ready[k]) m_full[k] = 1'b0;
      end
      if (acc) begin
        m_full[s] = 1'b1;
        m_word[s] = bus.in_data;
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model
  always @(negedge clk) begin
    int occ;
    occ = 0;
    for (int k = 0; k < 4; k++) begin
      occ += int'(m_full[k]);
      check($sformatf("model valid[%0d]", k), 32'(bus.out_valid[k]), 32'(m_full[k]));
      check($sformatf("model data%0d", k), 32'(dut_word(k)), 32'(m_word[k]));
    end
    check("model occupancy", 32'(bus.occupancy), 32'(occ));
    check("model in_ready", 32'(bus.in_ready), 32'(model_ready()));
    if (rst_n && !bus.flush && bus.out_valid[1] && bus.out_ready[1] && log1_n < 16) begin
      log1[log1_n] = bus.out_data1;
      log1_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [15:0] data);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = data;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_sel   = 2'd0;
    bus.in_data  = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    log1_n = 0;
    rst_n  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 4'b0000;
    idle();
    repeat (2) @(negedge clk);
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset occupancy", 32'(bus.occupancy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic routing, each word accepted the cycle it is presented
    for (int i = 0; i < 4; i++) begin
      send(2'(i), 16'h1111 * 16'(i + 1));
      @(negedge clk);
      check($sformatf("route in_ready sel%0d", i), 32'(bus.in_ready), 32'd1);
      tick();
    end
    idle();
    check("route out_valid", 32'(bus.out_valid), 32'h0000_000f);
    check("route data0", 32'(bus.out_data0), 32'h0000_1111);
    check("route data1", 32'(bus.out_data1), 32'h0000_2222);
    check("route data2", 32'(bus.out_data2), 32'h0000_3333);
    check("route data3", 32'(bus.out_data3), 32'h0000_4444);
    check("route occupancy", 32'(bus.occupancy), 32'd4);

    // Stall on full channel 2, then release
    send(2'd2, 16'hAAAA);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall in_ready", 32'(bus.in_ready), 32'd0);
      check("stall data2", 32'(bus.out_data2), 32'h0000_3333);
      tick();
    end
    bus.out_ready = 4'b0100;
    @(negedge clk);
    check("release in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    idle();
    bus.out_ready = 4'b0000;
    check("release data2", 32'(bus.out_data2), 32'h0000_AAAA);
    check("release valid2", 32'(bus.out_valid[2]), 32'd1);

    // Asynchronous reset mid-cycle with every channel full
    #2;
    rst_n = 1'b0;
    #1;
    check("async out_valid", 32'(bus.out_valid), 32'd0);
    check("async data0", 32'(bus.out_data0), 32'd0);
    check("async data2", 32'(bus.out_data2), 32'd0);
    check("async data3", 32'(bus.out_data3), 32'd0);
    check("async occupancy", 32'(bus.occupancy), 32'd0);
    check("async in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Streaming to channel 1 with every consumer ready
    bus.out_ready = 4'b1111;
    log1_n = 0;
    for (int i = 1; i <= 8; i++) begin
      send(2'd1, 16'(i));
      @(negedge clk);
      check("stream in_ready", 32'(bus.in_ready), 32'd1);
      tick();
    end
    idle();
    repeat (2) tick();
    check("stream count", 32'(log1_n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("stream word%0d", i), 32'(log1[i]), 32'(i + 1));
    end

    // Flush has priority over a pending accept
    bus.out_ready = 4'b0000;
    send(2'd0, 16'h5A5A);
    tick();
    send(2'd3, 16'hC3C3);
    tick();
    send(2'd0, 16'hDEAD);
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.flush = 1'b0;
    idle();
    check("flush out_valid", 32'(bus.out_valid), 32'd0);
    check("flush occupancy", 32'(bus.occupancy), 32'd0);
    check("flush data0 kept", 32'(bus.out_data0), 32'h0000_5A5A);

    // Independence: accept on 3 while 0 stalls and 1 drains
    send(2'd0, 16'h0A0A);
    tick();
    send(2'd1, 16'h0B0B);
    tick();
    bus.out_ready = 4'b0010;
    send(2'd3, 16'h0D0D);
    @(negedge clk);
    check("indep in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    idle();
    bus.out_ready = 4'b0000;
    check("indep out_valid", 32'(bus.out_valid), 32'h0000_0009);
    check("indep data3", 32'(bus.out_data3), 32'h0000_0D0D);
    check("indep data0", 32'(bus.out_data0), 32'h0000_0A0A);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
